mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for DmemAck before the access is aborted.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-low; a sampled 0 resets the block.
REQ-004 SHALL have ports StallM and FlushM, input, 1 each: hazard-unit hold and bubble-insert for the E/M register.
REQ-005 SHALL have ports PCSrcE, RegWriteE, MemtoRegE, MemWriteE, input, 1 each: execute-stage control outputs.
REQ-006 SHALL have ports ALUResultE and WriteDataE, input, 32 each: ALU result and store data from execute.
REQ-007 SHALL have port WriteAddrE, input, 4: destination register.
REQ-008 SHALL have ports DmemReq and DmemWe, output, 1 each: memory request and write enable.
REQ-009 SHALL have ports DmemAddr and DmemWdata, output, 32 each: memory address and write data.
REQ-010 SHALL have ports DmemRdata, input, 32, and DmemAck, input, 1: memory read data and completion.
REQ-011 SHALL have ports MemBusy, output, 1: stall request to the hazard unit; ALUResultM, output, 32: forwarding source for execute.
REQ-012 SHALL have ports PCSrcW, RegWriteW, MemtoRegW, AlignFaultW, BusFaultW, output, 1 each: writeback controls and faults.
REQ-013 SHALL have ports ReadDataW and ALUOutW, output, 32 each; WriteAddrW, output, 4.

Function
REQ-014 E/M register SHALL load all E inputs when StallM=0 and MemBusy=0, and hold otherwise; stall has priority over FlushM.
REQ-015 FlushM=1 while loading SHALL zero PCSrc, RegWrite, MemtoReg and MemWrite in the E/M register; data fields are don't-care.
REQ-016 The M-stage op is a memory op iff MemtoRegM or MemWriteM; it is misaligned iff ALUResultM[1:0]!=0.
REQ-017 FSM states IDLE and BUSY: IDLE holds with no aligned memory op; an aligned op in IDLE asserts DmemReq combinationally the same cycle.
REQ-018 IDLE with DmemAck=1 the same cycle SHALL complete with zero stall; DmemAck=0 SHALL move to BUSY.
REQ-019 In BUSY, DmemReq=1 and DmemAddr/DmemWdata/DmemWe SHALL stay stable; DmemAck=1 completes and returns to IDLE.
REQ-020 MemBusy SHALL equal DmemReq and not DmemAck.
REQ-021 A wait counter SHALL clear on IDLE->BUSY and increment each BUSY cycle; at TIMEOUT without ack the FSM SHALL return to IDLE, deassert DmemReq, and complete as a bus fault.
REQ-022 DmemAddr SHALL equal ALUResultM, DmemWdata SHALL equal WriteDataM, and DmemWe SHALL equal MemWriteM.
REQ-023 A misaligned op SHALL issue no request and SHALL not stall.
REQ-024 M/W register, when MemBusy=0, SHALL load:
- RegWrite, MemtoReg and PCSrc, each forced to 0 on fault
- DmemRdata, ALUResultM, WriteAddrM
- AlignFaultW and BusFaultW
REQ-025 M/W register, when MemBusy=1, SHALL load a bubble: all W controls and faults 0; each instruction retires exactly once.
REQ-026 Fault flags SHALL be single-cycle pulses per faulting instruction.
REQ-027 ALUResultM SHALL be driven from the E/M register.

Reset
REQ-028 reset=0 at a rising edge SHALL set the FSM to IDLE, clear the counter, and zero all E/M and M/W controls and faults.
REQ-029 After reset, DmemReq, MemBusy, RegWriteW, PCSrcW, MemtoRegW, AlignFaultW and BusFaultW SHALL read 0.
REQ-030 After reset, all 32-bit and 4-bit outputs SHALL read 0.
REQ-031 Reset during BUSY SHALL abandon the access with DmemReq=0 from the next cycle; a later stray DmemAck in IDLE without a request SHALL be ignored.

Structure
REQ-032 Shared package mem_pkg SHALL hold the state enum (IDLE, BUSY) and the default TIMEOUT constant.
REQ-033 The FSM and wait counter SHALL form one sub-module dmem_handshake; the pipeline registers stay in mem_stage.

Verification
REQ-034 Load at 0x100, DmemAck in the same cycle, DmemRdata=0xDEADBEEF -> no MemBusy; next cycle ReadDataW=0xDEADBEEF, RegWriteW=1, MemtoRegW=1.
REQ-035 Store 0x12345678 to 0x200, ack after 3 cycles -> MemBusy=1 for 3 cycles, DmemWe/Addr/Wdata stable throughout; exactly one retirement and bubbles during the wait.
REQ-036 Load at 0x103 -> DmemReq never asserted; next cycle AlignFaultW=1 for 1 cycle, RegWriteW=0.
REQ-037 TIMEOUT=4, no ack -> MemBusy for 4 cycles, then DmemReq=0 and a 1-cycle BusFaultW=1 with RegWriteW=0.
REQ-038 StallM=1 and FlushM=1 together for 2 cycles -> E/M contents unchanged; FlushM alone -> next M op has all controls 0.
REQ-039 reset=0 for 1 cycle mid-BUSY -> DmemReq=0 and all W controls 0 next cycle; a following DmemAck produces no writeback.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared handshake state encoding and default timeout for the
//               memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned c_TIMEOUT_DEFAULT = 255;

endpackage

`default_nettype wire

// File: rtl/dmem_handshake.sv
// ============================================================================
// Module      : dmem_handshake
// Description : Data-memory request/ack FSM with a bounded wait counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_handshake
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_ack,
    output logic o_req,
    output logic o_timeout
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          w_expired;

    // The IDLE request cycle counts as the first wait cycle, so abort on TIMEOUT-1
    assign w_expired = (r_state == BUSY) && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (!w_expired) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start && !i_ack) w_next = BUSY;
            BUSY:    if (w_expired || i_ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_req     = 1'b0;
        o_timeout = 1'b0;
        case (r_state)
            IDLE: o_req = i_start;
            BUSY: begin
                o_req     = !w_expired;
                o_timeout = w_expired;
            end
            default: o_req = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage: E/M and M/W registers around the
//               data-memory handshake, with alignment and bus-timeout faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallM,
    input  logic        FlushM,
    input  logic        PCSrcE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [3:0]  WriteAddrE,
    output logic        DmemReq,
    output logic        DmemWe,
    output logic [31:0] DmemAddr,
    output logic [31:0] DmemWdata,
    input  logic [31:0] DmemRdata,
    input  logic        DmemAck,
    output logic        MemBusy,
    output logic [31:0] ALUResultM,
    output logic        PCSrcW,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        AlignFaultW,
    output logic        BusFaultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [3:0]  WriteAddrW
);

    logic        r_pcsrc_m, r_regwrite_m, r_memtoreg_m, r_memwrite_m;
    logic [31:0] r_alu_m, r_wdata_m;
    logic [3:0]  r_waddr_m;
    logic        r_retired;
    logic        r_pcsrc_w, r_regwrite_w, r_memtoreg_w, r_align_w, r_bus_w;
    logic [31:0] r_rdata_w, r_alu_w;
    logic [3:0]  r_waddr_w;

    logic w_em_load, w_mem_op, w_misaligned, w_start, w_align_fault;
    logic w_bus_fault, w_fault, w_live;

    // An instruction held in M by StallM after it already retired must not
    // re-issue its access or retire a second time.
    assign w_live        = !r_retired;
    assign w_em_load     = !StallM && !MemBusy;
    assign w_mem_op      = (r_memtoreg_m || r_memwrite_m) && w_live;
    assign w_misaligned  = |r_alu_m[1:0];
    assign w_start       = w_mem_op && !w_misaligned;
    assign w_align_fault = w_mem_op && w_misaligned;
    assign w_fault       = w_align_fault || w_bus_fault;

    dmem_handshake #(
        .TIMEOUT (TIMEOUT)
    ) u_handshake (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_ack     (DmemAck),
        .o_req     (DmemReq),
        .o_timeout (w_bus_fault)
    );

    assign MemBusy    = DmemReq && !DmemAck;
    assign DmemWe     = r_memwrite_m;
    assign DmemAddr   = r_alu_m;
    assign DmemWdata  = r_wdata_m;
    assign ALUResultM = r_alu_m;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pcsrc_m    <= 1'b0;
            r_regwrite_m <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_memwrite_m <= 1'b0;
            r_alu_m      <= '0;
            r_wdata_m    <= '0;
            r_waddr_m    <= '0;
            r_retired    <= 1'b0;
        end else if (w_em_load) begin
            r_pcsrc_m    <= PCSrcE    && !FlushM;
            r_regwrite_m <= RegWriteE && !FlushM;
            r_memtoreg_m <= MemtoRegE && !FlushM;
            r_memwrite_m <= MemWriteE && !FlushM;
            r_alu_m      <= ALUResultE;
            r_wdata_m    <= WriteDataE;
            r_waddr_m    <= WriteAddrE;
            r_retired    <= 1'b0;
        end else if (!MemBusy) begin
            r_retired    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pcsrc_w    <= 1'b0;
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
            r_align_w    <= 1'b0;
            r_bus_w      <= 1'b0;
            r_rdata_w    <= '0;
            r_alu_w      <= '0;
            r_waddr_w    <= '0;
        end else if (!MemBusy) begin
            r_pcsrc_w    <= r_pcsrc_m    && w_live && !w_fault;
            r_regwrite_w <= r_regwrite_m && w_live && !w_fault;
            r_memtoreg_w <= r_memtoreg_m && w_live && !w_fault;
            r_align_w    <= w_align_fault;
            r_bus_w      <= w_bus_fault;
            r_rdata_w    <= DmemRdata;
            r_alu_w      <= r_alu_m;
            r_waddr_w    <= r_waddr_m;
        end else begin
            r_pcsrc_w    <= 1'b0;
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
            r_align_w    <= 1'b0;
            r_bus_w      <= 1'b0;
        end
    end

    assign PCSrcW      = r_pcsrc_w;
    assign RegWriteW   = r_regwrite_w;
    assign MemtoRegW   = r_memtoreg_w;
    assign AlignFaultW = r_align_w;
    assign BusFaultW   = r_bus_w;
    assign ReadDataW   = r_rdata_w;
    assign ALUOutW     = r_alu_w;
    assign WriteAddrW  = r_waddr_w;

endmodule

`default_nettype wire
